// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: ALU operation codes, RV32I major
// opcodes and the decoded field bundle handed from decode to the ID/EX register.
package alu_issue_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SLT  = 4'b0100,
        ALU_SLTU = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_EQ   = 4'b1000,
        ALU_XOR  = 4'b1001,
        ALU_SRL  = 4'b1010,
        ALU_SRA  = 4'b1011
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e           operation;
        logic [XLEN-1:0]   srca;
        logic [XLEN-1:0]   srcb;
        logic              is_branch;
        logic              br_invert;
        logic              illegal;
    } issue_fields_t;

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational RV32I decode into ALU operation and operand selection.
// Illegal combinations collapse to an all-zero field set with illegal raised.
module alu_op_decode
    import alu_issue_pkg::*;
(
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output issue_fields_t   fields
);

    alu_op_e         op;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic            is_branch;
    logic            br_invert;
    logic            bad;
    logic            r_type;
    logic            f7_nonzero;

    assign r_type     = (opcode == OPC_OP);
    assign f7_nonzero = (funct7 != F7_BASE);

    // Map opcode/funct fields to operation, operands and legality
    always_comb begin
        op        = ALU_AND;
        srca      = '0;
        srcb      = '0;
        is_branch = 1'b0;
        br_invert = 1'b0;
        bad       = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                srca = rs1_data;
                srcb = r_type ? rs2_data : imm;
                case (funct3)
                    3'b000: begin
                        // For immediates funct7 is part of the immediate and means nothing
                        if (r_type && funct7 == F7_ALT) op = ALU_SUB;
                        else begin
                            op  = ALU_ADD;
                            bad = r_type && f7_nonzero;
                        end
                    end
                    3'b001: begin op = ALU_SLL;  bad = f7_nonzero;           end
                    3'b010: begin op = ALU_SLT;  bad = r_type && f7_nonzero; end
                    3'b011: begin op = ALU_SLTU; bad = r_type && f7_nonzero; end
                    3'b100: begin op = ALU_XOR;  bad = r_type && f7_nonzero; end
                    3'b101: begin
                        op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        bad = f7_nonzero && (funct7 != F7_ALT);
                    end
                    3'b110: begin op = ALU_OR;   bad = r_type && f7_nonzero; end
                    default: begin op = ALU_AND; bad = r_type && f7_nonzero; end
                endcase
            end
            OPC_BRANCH: begin
                srca      = rs1_data;
                srcb      = rs2_data;
                is_branch = 1'b1;
                br_invert = funct3[0];
                case (funct3[2:1])
                    2'b00:   op = ALU_EQ;
                    2'b10:   op = ALU_SLT;
                    2'b11:   op = ALU_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                op   = ALU_ADD;
                srca = rs1_data;
                srcb = imm;
            end
            OPC_LUI: begin
                op   = ALU_ADD;
                srcb = imm;
            end
            OPC_AUIPC: begin
                op   = ALU_ADD;
                srca = pc;
                srcb = imm;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU produces the link address pc+4
                op   = ALU_ADD;
                srca = pc;
                srcb = XLEN'(4);
            end
            default: bad = 1'b1;
        endcase
        // ALU shifts by the full SrcB, so only the 5-bit shamt may survive
        if (is_shift(op)) srcb[XLEN-1:5] = '0;
        if (bad) begin
            op        = ALU_AND;
            srca      = '0;
            srcb      = '0;
            is_branch = 1'b0;
            br_invert = 1'b0;
        end
    end

    assign fields = '{operation: op, srca: srca, srcb: srcb,
                      is_branch: is_branch, br_invert: br_invert, illegal: bad};

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register feeding the ALU with a valid/ready handshake.
// Optional build macro ALU_ISSUE_SKID_EN adds a one-entry skid buffer so that
// in_ready is registered and has no combinational path from out_ready.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_opcode,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [DATA_WIDTH-1:0]    in_rs1_data,
    input  logic [DATA_WIDTH-1:0]    in_rs2_data,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] out_operation,
    output logic [DATA_WIDTH-1:0]    out_srca,
    output logic [DATA_WIDTH-1:0]    out_srcb,
    output logic                     out_is_branch,
    output logic                     out_br_invert,
    output logic                     out_illegal
);

    issue_fields_t dec_fields;
    issue_fields_t out_q;
    logic          out_valid_q;
    logic          accept;

    alu_op_decode u_decode (
        .opcode   (in_opcode),
        .funct3   (in_funct3),
        .funct7   (in_funct7),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .imm      (in_imm),
        .pc       (in_pc),
        .fields   (dec_fields)
    );

`ifdef ALU_ISSUE_SKID_EN
    issue_fields_t skid_q;
    logic          skid_valid_q;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && !skid_valid_q && !flush;

    // Output register refills from the skid entry first; a stalled accept parks in the skid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec_fields;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec_fields;
            skid_valid_q <= 1'b1;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Capture on accept, drop valid once drained, flush overrides everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_q       <= dec_fields;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid     = out_valid_q;
    assign out_operation = out_q.operation;
    assign out_srca      = out_q.srca;
    assign out_srcb      = out_q.srcb;
    assign out_is_branch = out_q.is_branch;
    assign out_br_invert = out_q.br_invert;
    assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: an instruction-level reference model
// with an in-order expectation queue, plus directed vectors with literal results.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } instr_t;

    // {op, srca, srcb, is_branch, br_invert, illegal}
    typedef logic [70:0] exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic [31:0] in_imm = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_operation;
    logic [31:0] out_srca;
    logic [31:0] out_srcb;
    logic        out_is_branch;
    logic        out_br_invert;
    logic        out_illegal;

    int tests = 0;
    int fails = 0;

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct3     (in_funct3),
        .in_funct7     (in_funct7),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_imm        (in_imm),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_operation (out_operation),
        .out_srca      (out_srca),
        .out_srcb      (out_srcb),
        .out_is_branch (out_is_branch),
        .out_br_invert (out_br_invert),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t out_vec();
        return {out_operation, out_srca, out_srcb, out_is_branch, out_br_invert, out_illegal};
    endfunction

    // ALU mnemonic chosen by funct3 for register/immediate arithmetic
    function automatic logic [3:0] alu_by_f3(input logic [2:0] f3);
        case (f3)
            3'd0: return 4'h2;  // add
            3'd1: return 4'h3;  // sll
            3'd2: return 4'h4;  // slt
            3'd3: return 4'h5;  // sltu
            3'd4: return 4'h9;  // xor
            3'd5: return 4'hA;  // srl
            3'd6: return 4'h1;  // or
            default: return 4'h0;  // and
        endcase
    endfunction

    function automatic exp_t ref_decode(input instr_t i);
        logic [3:0]  op = 4'h0;
        logic [31:0] a = 0, b = 0;
        logic        br = 0, inv = 0, ok = 1;
        if (i.opc == 7'b0110011) begin
            op = alu_by_f3(i.f3); a = i.rs1; b = i.rs2;
            if (i.f7 == 7'h20) begin
                if (i.f3 == 3'd0) op = 4'h6;
                else if (i.f3 == 3'd5) op = 4'hB;
                else ok = 0;
            end else if (i.f7 != 7'h00) ok = 0;
        end else if (i.opc == 7'b0010011) begin
            op = alu_by_f3(i.f3); a = i.rs1; b = i.imm;
            if (i.f3 == 3'd1 && i.f7 != 7'h00) ok = 0;
            if (i.f3 == 3'd5) begin
                if (i.f7 == 7'h20) op = 4'hB;
                else if (i.f7 != 7'h00) ok = 0;
            end
        end else if (i.opc == 7'b1100011) begin
            a = i.rs1; b = i.rs2; br = 1; inv = i.f3[0];
            if (i.f3 == 3'd0 || i.f3 == 3'd1) op = 4'h8;
            else if (i.f3 == 3'd4 || i.f3 == 3'd5) op = 4'h4;
            else if (i.f3 == 3'd6 || i.f3 == 3'd7) op = 4'h5;
            else ok = 0;
        end else if (i.opc == 7'b0000011 || i.opc == 7'b0100011) begin
            op = 4'h2; a = i.rs1; b = i.imm;
        end else if (i.opc == 7'b0110111) begin
            op = 4'h2; a = 0; b = i.imm;
        end else if (i.opc == 7'b0010111) begin
            op = 4'h2; a = i.pc; b = i.imm;
        end else if (i.opc == 7'b1101111 || i.opc == 7'b1100111) begin
            op = 4'h2; a = i.pc; b = 32'd4;
        end else ok = 0;
        if (op == 4'h3 || op == 4'hA || op == 4'hB) b = b % 32;
        if (!ok) return {4'h0, 64'h0, 3'b001};
        return {op, a, b, br, inv, 1'b0};
    endfunction

    function automatic instr_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic [31:0] pc);
        return '{opc: opc, f3: f3, f7: f7, rs1: rs1, rs2: rs2, imm: imm, pc: pc};
    endfunction

    task automatic set_in(input instr_t i);
        in_opcode = i.opc; in_funct3 = i.f3; in_funct7 = i.f7;
        in_rs1_data = i.rs1; in_rs2_data = i.rs2; in_imm = i.imm; in_pc = i.pc;
    endtask

    // Reference model: expected outputs in acceptance order
    exp_t exp_q[$];
    exp_t cur_exp;
    logic acc_n = 0, drn_n = 0;

    always @(negedge clk) begin
        if (!reset) begin
            acc_n = 0;
            drn_n = 0;
        end else begin
            acc_n   = in_valid && in_ready && !flush;
            drn_n   = out_valid && out_ready;
            cur_exp = ref_decode(mk(in_opcode, in_funct3, in_funct7, in_rs1_data,
                                    in_rs2_data, in_imm, in_pc));
            if (out_valid) begin
                if (exp_q.size() == 0) chk("spurious_out_valid", 71'(out_valid), 71'(0));
                else chk("model_fields", out_vec(), exp_q[0]);
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) exp_q.delete();
        else begin
            if (drn_n && exp_q.size() > 0) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (acc_n) exp_q.push_back(cur_exp);
        end
    end

    // Present one instruction until it is accepted (bounded)
    task automatic drive(input instr_t i);
        logic done = 0;
        set_in(i);
        in_valid = 1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!done) chk("accept_timeout", 71'(0), 71'(1));
    endtask

    instr_t strm[8];
    logic [15:0] rdy_pat = 16'b1011_0001_1101_0111;

    initial begin
        instr_t x, y;
        int took, idx, cyc;
        logic fire;

        #1;
        chk("reset_outputs", out_vec(), 71'(0));
        chk("reset_valid", 71'(out_valid), 71'(0));
        repeat (3) @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", 71'(in_ready), 71'(1));

        // Directed decode vectors, downstream always ready
        drive(mk(7'b0110011, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0));
        chk("add_fields", out_vec(), {4'h2, 32'd5, 32'd7, 3'b000});
        chk("add_valid", 71'(out_valid), 71'(1));
        drive(mk(7'b0010011, 3'b101, 7'h20, 32'h8000_0000, 32'd0, 32'h405, 32'd0));
        chk("srai_fields", out_vec(), {4'hB, 32'h8000_0000, 32'h5, 3'b000});
        drive(mk(7'b0010011, 3'b101, 7'h01, 32'd1, 32'd0, 32'h025, 32'd0));
        chk("srai_bad_f7", out_vec(), {4'h0, 64'h0, 3'b001});
        drive(mk(7'b1100011, 3'b111, 7'h00, 32'd3, 32'd9, 32'd0, 32'd0));
        chk("bgeu_fields", out_vec(), {4'h5, 32'd3, 32'd9, 3'b110});
        drive(mk(7'b1100011, 3'b001, 7'h00, 32'd4, 32'd4, 32'd0, 32'd0));
        chk("bne_fields", out_vec(), {4'h8, 32'd4, 32'd4, 3'b110});
        drive(mk(7'b0110011, 3'b001, 7'h00, 32'd1, 32'hFFFF_FFE3, 32'd0, 32'd0));
        chk("sll_mask", out_vec(), {4'h3, 32'd1, 32'd3, 3'b000});
        drive(mk(7'b0110011, 3'b000, 7'h20, 32'd9, 32'd2, 32'd0, 32'd0));
        chk("sub_fields", out_vec(), {4'h6, 32'd9, 32'd2, 3'b000});
        drive(mk(7'b0110111, 3'b000, 7'h00, 32'd7, 32'd0, 32'h1234_5000, 32'd0));
        chk("lui_fields", out_vec(), {4'h2, 32'd0, 32'h1234_5000, 3'b000});
        drive(mk(7'b1101111, 3'b000, 7'h00, 32'd7, 32'd0, 32'h800, 32'h100));
        chk("jal_fields", out_vec(), {4'h2, 32'h100, 32'd4, 3'b000});
        drive(mk(7'b1100011, 3'b010, 7'h00, 32'd1, 32'd2, 32'd0, 32'd0));
        chk("branch_f3_010", out_vec(), {4'h0, 64'h0, 3'b001});
        drive(mk(7'b1111111, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 32'd4));
        chk("bad_opcode", out_vec(), {4'h0, 64'h0, 3'b001});
        drive(mk(7'b0110011, 3'b000, 7'h01, 32'd1, 32'd2, 32'd0, 32'd0));
        chk("add_bad_f7", out_vec(), {4'h0, 64'h0, 3'b001});
        chk("illegal_flows", 71'(out_valid), 71'(1));
        drive(mk(7'b0010111, 3'b000, 7'h00, 32'd0, 32'd0, 32'h2000, 32'h40));
        chk("auipc_fields", out_vec(), {4'h2, 32'h40, 32'h2000, 3'b000});
        @(posedge clk); #1;
        chk("drain_clears_valid", 71'(out_valid), 71'(0));

        // Backpressure: X held for 3 cycles while Y waits
        out_ready = 0;
        x = mk(7'b0110011, 3'b000, 7'h00, 32'd11, 32'd22, 32'd0, 32'd0);
        y = mk(7'b0110011, 3'b100, 7'h00, 32'hF0, 32'h0F, 32'd0, 32'd0);
        drive(x);
        set_in(y);
        in_valid = 1;
        took = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            if (fire) took++;
            @(posedge clk); #1;
            if (fire) in_valid = 0;
            chk("bp_hold", out_vec(), {4'h2, 32'd11, 32'd22, 3'b000});
        end
        out_ready = 1;
        @(negedge clk);
        fire = in_valid && in_ready;
        if (fire) took++;
        @(posedge clk); #1;
        in_valid = 0;
        chk("bp_next", out_vec(), {4'h9, 32'hF0, 32'h0F, 3'b000});
        chk("bp_accept_once", 71'(took), 71'(1));
        @(posedge clk); #1;
        chk("bp_empty", 71'(out_valid), 71'(0));

        // Stream with irregular downstream readiness
        for (int k = 0; k < 8; k++)
            strm[k] = mk(7'b0010011, 3'(k), (k == 5) ? 7'h20 : 7'h00, 32'(100 + k), 32'd0, 32'(k * 3 + 1), 32'd0);
        idx = 0;
        cyc = 0;
        while ((idx < 8 || out_valid) && cyc < 200) begin
            if (idx < 8) set_in(strm[idx]);
            in_valid = (idx < 8);
            out_ready = rdy_pat[cyc % 16];
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) idx++;
            cyc++;
        end
        in_valid = 0;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("stream_all_sent", 71'(idx), 71'(8));
        chk("stream_queue_empty", 71'(exp_q.size()), 71'(0));

        // Flush kills the held output and the input presented with it
        out_ready = 0;
        drive(x);
        set_in(y);
        in_valid = 1;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        in_valid = 0;
        chk("flush_clears", 71'(out_valid), 71'(0));
        out_ready = 1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("flush_no_emit", 71'(out_valid), 71'(0));
        end

        // Asynchronous reset mid-stream
        out_ready = 0;
        drive(y);
        @(negedge clk); #2;
        reset = 0;
        #1;
        chk("async_reset_outputs", out_vec(), 71'(0));
        chk("async_reset_valid", 71'(out_valid), 71'(0));
        @(posedge clk); #1;
        reset = 1;
        out_ready = 1;
        chk("in_ready_after_rerelease", 71'(in_ready), 71'(1));
        drive(mk(7'b0110011, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0));
        chk("add_after_reset", out_vec(), {4'h2, 32'd5, 32'd7, 3'b000});
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
